// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH-output PWM with prescaler, programmable top and
// double-buffered duty/top registers that swap only at the period wrap.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W = 8,
  parameter int PRESC_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [NUM_CH-1:0]  en_out,
  input  logic [NUM_CH-1:0]  en_pwm,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [CNT_W-1:0]   top_in,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [CNT_W-1:0]   wr_duty,
  output logic [NUM_CH-1:0]  out,
  output logic               period_start
);
  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0] cnt, top_shadow, top_active;
  logic [CNT_W-1:0] duty_shadow [NUM_CH];
  logic [CNT_W-1:0] duty_active [NUM_CH];
  logic [NUM_CH-1:0] out_next;
  logic tick, wrap, wr_ok;
  // ">=" rather than "==" so lowering prescale or top mid-count never stalls
  assign tick = run && presc_cnt >= prescale;
  assign wrap = tick && cnt >= top_active;
  assign wr_ok = wr_en && ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
  always_comb begin
    out_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      out_next[i] = en_out[i] && (!en_pwm[i] || cnt < duty_active[i] || &duty_active[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      cnt <= '0;
      top_shadow <= '1;
      top_active <= '1;
      period_start <= 1'b0;
      out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      top_shadow <= top_in;
      if (wr_ok) duty_shadow[wr_ch] <= wr_duty;
      period_start <= wrap;
      out <= out_next;
      if (!run) begin
        presc_cnt <= '0;
        cnt <= '0;
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
      end
      // while stopped the active copies track the shadows so a restart uses current values
      if (!run || wrap) begin
        duty_active <= duty_shadow;
        top_active <= top_shadow;
      end
    end
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed table of PWM configurations plus hand-written
// sequences for reset, modes, run gating, prescale change and double buffering.
module tb_pwm_multichannel;
  localparam int N = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [N-1:0] en_out = '0;
  logic [N-1:0] en_pwm = '0;
  logic [7:0] prescale = 8'd0;
  logic [7:0] top_in = 8'd255;
  logic wr_en = 1'b0;
  logic [3:0] wr_ch = 4'd0;
  logic [7:0] wr_duty = 8'd0;
  logic [N-1:0] out;
  logic period_start;
  int checks = 0;
  int errors = 0;

  pwm_multichannel #(.NUM_CH(N), .CNT_W(8), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .en_out(en_out), .en_pwm(en_pwm),
    .prescale(prescale), .top_in(top_in), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] top;
    logic [7:0] presc;
    logic [3:0][7:0] d;
    int period;
    logic [3:0][15:0] hi;
  } vec_t;
  vec_t v [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [7:0] d);
    wr_ch = ch;
    wr_duty = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input string name, input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < lim);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL %s: no period_start within %0d clocks", name, lim);
    end
  endtask

  task automatic win(input int wr_at, input logic [7:0] wd, output int h);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      if (out[0]) h++;
      if (i == wr_at) begin
        wr_ch = 4'd0;
        wr_duty = wd;
        wr_en = 1'b1;
      end else wr_en = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int n, acc, h;
    int hc [4];
    // d and hi are listed channel 3 first
    v[0] = '{8'd255, 8'd0, {8'd44, 8'd255, 8'd128, 8'd0}, 256, {16'd44, 16'd256, 16'd128, 16'd0}};
    v[1] = '{8'd9, 8'd3, {8'd255, 8'd10, 8'd0, 8'd5}, 40, {16'd40, 16'd40, 16'd0, 16'd20}};
    v[2] = '{8'd99, 8'd1, {8'd100, 8'd99, 8'd1, 8'd50}, 200, {16'd200, 16'd198, 16'd2, 16'd100}};
    v[3] = '{8'd0, 8'd2, {8'd255, 8'd3, 8'd1, 8'd0}, 3, {16'd3, 16'd3, 16'd3, 16'd0}};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_ps", int'(period_start), 0);
    run = 1'b1;
    en_out = '1;
    en_pwm = '1;
    acc = 0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out != '0) acc++;
      if (period_start) n++;
    end
    chk("zero_duty_quiet", acc, 0);
    chk("ps_count_1000", n, 3);

    for (int k = 0; k < 4; k++) begin
      run = 1'b0;
      top_in = v[k].top;
      prescale = v[k].presc;
      for (int c = 0; c < 4; c++) wr(4'(c), v[k].d[c]);
      repeat (3) @(negedge clk);
      run = 1'b1;
      wait_ps($sformatf("v%0d_first_ps", k), 2000, n);
      wait_ps($sformatf("v%0d_second_ps", k), 2000, n);
      chk($sformatf("v%0d_period", k), n, v[k].period);
      for (int c = 0; c < 4; c++) hc[c] = 0;
      for (int i = 0; i < v[k].period; i++) begin
        for (int c = 0; c < 4; c++) if (out[c]) hc[c]++;
        @(negedge clk);
      end
      for (int c = 0; c < 4; c++) chk($sformatf("v%0d_high_ch%0d", k, c), hc[c], int'(v[k].hi[c]));
    end

    run = 1'b0;
    for (int c = 0; c < N; c++) wr(4'(c), 8'd0);
    repeat (3) @(negedge clk);
    chk("all_zero_stopped", int'(out), 0);
    wr(4'd12, 8'd7);
    wr(4'd15, 8'd7);
    repeat (3) @(negedge clk);
    chk("bad_ch_ignored", int'(out), 0);
    wr(4'd5, 8'd100);
    en_out = 12'hfdf;
    en_pwm = 12'hfbf;
    repeat (3) @(negedge clk);
    chk("ch5_disabled", int'(out[5]), 0);
    chk("ch6_static", int'(out[6]), 1);
    en_out = '1;
    en_pwm = '1;
    wr(4'd5, 8'd0);

    top_in = 8'd9;
    prescale = 8'd3;
    wr(4'd0, 8'd5);
    repeat (3) @(negedge clk);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (period_start) acc++;
    end
    chk("stopped_no_ps", acc, 0);
    chk("stopped_out0_high", int'(out[0]), 1);
    run = 1'b1;
    wait_ps("run_first_ps", 200, n);
    chk("run_first_ps_delay", n, 40);
    repeat (10) @(negedge clk);
    prescale = 8'd1;
    wait_ps("presc_change_ps", 200, n);
    wait_ps("presc_change_ps2", 200, n);
    chk("presc_change_period", n, 20);

    top_in = 8'd255;
    prescale = 8'd0;
    wr(4'd0, 8'd64);
    wait_ps("db_sync1", 600, n);
    wait_ps("db_sync2", 600, n);
    win(100, 8'd192, h);
    chk("db_mid_write_keeps", h, 64);
    chk("db_ps1", int'(period_start), 1);
    win(255, 8'd32, h);
    chk("db_new_duty", h, 192);
    chk("db_ps2", int'(period_start), 1);
    win(-1, 8'd0, h);
    chk("db_wrap_write_deferred", h, 192);
    chk("db_ps3", int'(period_start), 1);
    win(-1, 8'd0, h);
    chk("db_wrap_write_applied", h, 32);
    chk("db_ps4", int'(period_start), 1);

    en_pwm = '0;
    repeat (2) @(negedge clk);
    chk("static_all_high", int'(out), 12'hfff);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(out), 0);
    chk("async_reset_ps", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    en_pwm = '1;
    repeat (2) @(negedge clk);
    chk("post_reset_duty_cleared", int'(out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
